pipelined_data_memory: RTL and testbench

Byte-addressable, little-endian data memory with a valid/ready request port, a configurable-latency response pipeline, sized loads and stores (byte/half/word/double) with sign or zero extension, and misalignment detection. It replaces the flat single-cycle data memory in the MEM stage of pipelined CPU configurations that need registered read latency and back-pressure from the writeback side.

---
 rtl/pipelined_data_memory.sv | 118 +++++++++++
 tb/tb_pipelined_data_memory.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_data_memory.sv
// rtl/pipelined_data_memory.sv - byte-addressable little-endian data memory with sized access
// and a back-pressured, fixed-latency response pipeline.
module pipelined_data_memory #(
  parameter int BitWidth    = 32,
  parameter int Capacity    = 128,
  parameter int ReadLatency = 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        reqValid,
  output logic                        reqReady,
  input  logic                        write,
  input  logic [$clog2(Capacity)-1:0] addr,
  input  logic [1:0]                  size,
  input  logic                        signedLoad,
  input  logic [BitWidth-1:0]         wData,
  output logic                        respValid,
  input  logic                        respReady,
  output logic [BitWidth-1:0]         rData,
  output logic                        error
);

  localparam int AW = $clog2(Capacity);
  localparam int NB = BitWidth / 8;
  localparam logic [AW:0] CapLimit = (AW + 1)'(Capacity);

  logic [7:0]             mem [Capacity];
  logic [Capacity-1:0]    we;
  logic [7:0]             wbyte [Capacity];

  logic [ReadLatency-1:0] stage_valid;
  logic [ReadLatency-1:0] stage_error;
  logic [BitWidth-1:0]    stage_data [ReadLatency];

  logic                   adv;
  logic                   accept;
  logic                   legal;
  logic [3:0]             nbytes;
  logic [BitWidth-1:0]    raw;
  logic [BitWidth-1:0]    ext;
  logic                   sign;
  logic [BitWidth-1:0]    load_data;

  assign nbytes = 4'd1 << size;
  assign legal  = ((addr & AW'(nbytes - 4'd1)) == '0) && (int'(nbytes) <= NB);

  // The whole pipeline moves as a unit; a stalled last stage freezes everything upstream.
  assign adv      = ~stage_valid[ReadLatency-1] | respReady;
  assign reqReady = adv & reset;
  assign accept   = reqValid & reqReady;

  always_comb begin
    raw = '0;
    for (int i = 0; i < NB; i++) begin
      logic [AW:0] idx;
      idx = {1'b0, addr} + (AW + 1)'(i);
      if (i < int'(nbytes) && idx < CapLimit) raw[8*i +: 8] = mem[idx[AW-1:0]];
    end
  end

  always_comb begin
    case (size)
      2'd0:    sign = raw[7];
      2'd1:    sign = raw[15];
      2'd2:    sign = raw[31];
      default: sign = raw[BitWidth-1];
    endcase
    ext = '0;
    for (int j = 0; j < BitWidth; j++) begin
      if (j < 8 * int'(nbytes)) ext[j] = raw[j];
      else                      ext[j] = sign & signedLoad;
    end
  end

  assign load_data = (legal && !write) ? ext : '0;

  // Per-byte write enables: byte b is written when it falls inside [addr, addr+nbytes).
  always_comb begin
    for (int b = 0; b < Capacity; b++) begin
      logic [AW:0] diff;
      diff     = (AW + 1)'(b) - {1'b0, addr};
      we[b]    = accept & write & legal & ~diff[AW] & (diff < (AW + 1)'(nbytes));
      wbyte[b] = 8'(wData >> {diff[2:0], 3'b000});
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < Capacity; b++) mem[b] <= '0;
    end else begin
      for (int b = 0; b < Capacity; b++) begin
        if (we[b]) mem[b] <= wbyte[b];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stage_valid <= '0;
      stage_error <= '0;
      for (int k = 0; k < ReadLatency; k++) stage_data[k] <= '0;
    end else if (adv) begin
      stage_valid[0] <= accept;
      stage_error[0] <= accept & ~legal;
      stage_data[0]  <= accept ? load_data : '0;
      for (int k = 1; k < ReadLatency; k++) begin
        stage_valid[k] <= stage_valid[k-1];
        stage_error[k] <= stage_error[k-1];
        stage_data[k]  <= stage_data[k-1];
      end
    end
  end

  assign respValid = stage_valid[ReadLatency-1];
  assign error     = stage_error[ReadLatency-1];
  assign rData     = stage_data[ReadLatency-1];

endmodule

// File: tb/tb_pipelined_data_memory.sv
// tb/tb_pipelined_data_memory.sv - scoreboard bench for pipelined_data_memory
// (32-bit/latency-2 and 64-bit/latency-3 instances).
module tb_pipelined_data_memory;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        wr = 1'b0;
  logic [6:0]  addr = '0;
  logic [1:0]  size = '0;
  logic        signed_load = 1'b0;
  logic [63:0] wdata = '0;
  logic        resp_ready = 1'b1;
  logic        sel = 1'b0;

  logic        rr32, rv32, er32, rr64, rv64, er64;
  logic [31:0] rd32;
  logic [63:0] rd64;
  logic        req_ready, resp_v, resp_e;
  logic [63:0] rdata;

  always #5 clock = ~clock;

  pipelined_data_memory #(.BitWidth(32), .Capacity(128), .ReadLatency(2)) u32 (
    .clock(clock), .reset(reset), .reqValid(req_valid & ~sel), .reqReady(rr32),
    .write(wr), .addr(addr), .size(size), .signedLoad(signed_load), .wData(wdata[31:0]),
    .respValid(rv32), .respReady(resp_ready), .rData(rd32), .error(er32)
  );

  pipelined_data_memory #(.BitWidth(64), .Capacity(128), .ReadLatency(3)) u64 (
    .clock(clock), .reset(reset), .reqValid(req_valid & sel), .reqReady(rr64),
    .write(wr), .addr(addr), .size(size), .signedLoad(signed_load), .wData(wdata),
    .respValid(rv64), .respReady(resp_ready), .rData(rd64), .error(er64)
  );

  assign req_ready = sel ? rr64 : rr32;
  assign resp_v    = sel ? rv64 : rv32;
  assign resp_e    = sel ? er64 : er32;
  assign rdata     = sel ? rd64 : {32'h0, rd32};

  typedef struct {
    logic        err;
    logic [63:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (reset && resp_v && resp_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp got err=%0b data=%h expected no response", resp_e, rdata);
      end else begin
        mon_e = sb.pop_front();
        if (resp_e !== mon_e.err || rdata !== mon_e.data) begin
          errors++;
          $display("FAIL resp_data got err=%0b data=%h expected err=%0b data=%h",
                   resp_e, rdata, mon_e.err, mon_e.data);
        end
        if (mon_e.due >= 0) begin
          checks++;
          if (cyc != mon_e.due) begin
            errors++;
            $display("FAIL resp_latency got cycle=%0d expected cycle=%0d", cyc, mon_e.due);
          end
        end
      end
    end
  end

  task automatic issue(input logic w, input logic [6:0] a, input logic [1:0] sz, input logic sg,
                       input logic [63:0] d, input logic e_err, input logic [63:0] e_data,
                       input logic chk_lat);
    exp_t e;
    bit   ok = 1'b0;
    req_valid = 1'b1; wr = w; addr = a; size = sz; signed_load = sg; wdata = d;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clock);
      ok = req_ready;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL issue_timeout got reqReady=0 expected 1 addr=%0d", a);
    end else begin
      e.err  = e_err;
      e.data = e_data;
      e.due  = chk_lat ? cyc + 1 + (sel ? 2 : 1) : -1;
      sb.push_back(e);
    end
    @(posedge clock); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clock);
    @(posedge clock); #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got pending=%0d expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({rv32, er32, rr32, rd32} !== 35'h0) begin
      errors++;
      $display("FAIL reset32 got v=%0b e=%0b rdy=%0b d=%h expected all 0", rv32, er32, rr32, rd32);
    end
    checks++;
    if ({rv64, er64, rr64, rd64} !== 67'h0) begin
      errors++;
      $display("FAIL reset64 got v=%0b e=%0b rdy=%0b d=%h expected all 0", rv64, er64, rr64, rd64);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({rr32, rr64} !== 2'b11) begin
      errors++;
      $display("FAIL reset_release got rdy32=%0b rdy64=%0b expected 1 1", rr32, rr64);
    end
  endtask

  task automatic test_sized_load();
    issue(1, 4, 2, 0, 64'hDEADBEEF, 0, 64'h0, 1);
    issue(0, 7, 0, 1, 64'h0, 0, 64'hFFFFFFDE, 1);
    issue(0, 4, 1, 0, 64'h0, 0, 64'h0000BEEF, 1);
    issue(0, 6, 1, 1, 64'h0, 0, 64'hFFFFDEAD, 1);
    issue(0, 0, 2, 1, 64'h0, 0, 64'h0, 1);
    drain();
  endtask

  task automatic test_byte_lane();
    issue(1, 5, 0, 0, 64'hFFFFFF5A, 0, 64'h0, 1);
    issue(0, 4, 2, 0, 64'h0, 0, 64'hDEAD5AEF, 1);
    drain();
  endtask

  task automatic test_misaligned();
    issue(1, 6, 2, 0, 64'h12345678, 1, 64'h0, 1);
    issue(0, 4, 2, 0, 64'h0, 0, 64'hDEAD5AEF, 1);
    issue(0, 0, 3, 0, 64'h0, 1, 64'h0, 1);
    issue(0, 3, 1, 1, 64'h0, 1, 64'h0, 1);
    issue(1, 8, 3, 0, 64'hFFFFFFFF, 1, 64'h0, 1);
    issue(0, 8, 2, 0, 64'h0, 0, 64'h0, 1);
    drain();
  endtask

  task automatic test_back_to_back();
    issue(1, 12, 2, 0, 64'h11223344, 0, 64'h0, 1);
    issue(0, 12, 0, 0, 64'h0, 0, 64'h44, 1);
    issue(1, 14, 1, 0, 64'h0000A5A5, 0, 64'h0, 1);
    issue(0, 12, 2, 0, 64'h0, 0, 64'hA5A53344, 1);
    issue(0, 14, 1, 1, 64'h0, 0, 64'hFFFFA5A5, 1);
    drain();
  endtask

  task automatic test_wide();
    issue(1, 8, 3, 0, 64'h0123456789ABCDEF, 0, 64'h0, 1);
    issue(0, 12, 2, 1, 64'h0, 0, 64'h0000000001234567, 1);
    issue(0, 15, 0, 1, 64'h0, 0, 64'h0000000000000001, 1);
    issue(0, 8, 0, 1, 64'h0, 0, 64'hFFFFFFFFFFFFFFEF, 1);
    issue(0, 10, 1, 1, 64'h0, 0, 64'hFFFFFFFFFFFF89AB, 1);
    issue(0, 8, 3, 0, 64'h0, 0, 64'h0123456789ABCDEF, 1);
    issue(0, 4, 3, 0, 64'h0, 1, 64'h0, 1);
    drain();
  endtask

  task automatic test_backpressure();
    fork
      begin
        issue(0, 8, 0, 0, 64'h0, 0, 64'hEF, 0);
        issue(0, 9, 0, 0, 64'h0, 0, 64'hCD, 0);
        issue(0, 10, 1, 0, 64'h0, 0, 64'h89AB, 0);
        issue(0, 12, 2, 0, 64'h0, 0, 64'h01234567, 0);
        issue(0, 8, 3, 0, 64'h0, 0, 64'h0123456789ABCDEF, 0);
      end
      begin
        bit          seen = 1'b0;
        logic [63:0] hold_d;
        logic        hold_e;
        for (int i = 0; i < 20 && !seen; i++) begin
          @(posedge clock); #1;
          seen = resp_v;
        end
        resp_ready = 1'b0;
        hold_d = rdata;
        hold_e = resp_e;
        for (int i = 0; i < 5; i++) begin
          @(negedge clock);
          checks++;
          if (resp_v !== 1'b1 || rdata !== hold_d || resp_e !== hold_e || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold got v=%0b d=%h e=%0b rdy=%0b expected v=1 d=%h e=%0b rdy=0",
                     resp_v, rdata, resp_e, req_ready, hold_d, hold_e);
          end
        end
        @(posedge clock); #1;
        resp_ready = 1'b1;
      end
    join
    drain();
  endtask

  task automatic test_reset_mid();
    issue(0, 8, 3, 0, 64'h0, 0, 64'h0123456789ABCDEF, 0);
    issue(0, 12, 2, 0, 64'h0, 0, 64'h01234567, 0);
    reset = 1'b0;
    #1;
    checks++;
    if (rv64 !== 1'b0 || rr64 !== 1'b0 || rd64 !== 64'h0) begin
      errors++;
      $display("FAIL reset_mid got v=%0b rdy=%0b d=%h expected 0 0 0", rv64, rr64, rd64);
    end
    sb.delete();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (rr64 !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_release got rdy=%0b expected 1", rr64);
    end
    issue(0, 8, 3, 0, 64'h0, 0, 64'h0, 1);
    issue(0, 12, 2, 1, 64'h0, 0, 64'h0, 1);
    drain();
    sel = 1'b0;
    issue(0, 4, 2, 0, 64'h0, 0, 64'h0, 1);
    issue(0, 12, 2, 0, 64'h0, 0, 64'h0, 1);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    @(posedge clock); #1;
    sel = 1'b0;
    test_sized_load();
    test_byte_lane();
    test_misaligned();
    test_back_to_back();
    sel = 1'b1;
    test_wide();
    test_backpressure();
    test_reset_mid();
    repeat (5) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
